// File: rtl/jtbubl_colmix.sv
// jtbubl_colmix: palette lookup and blanking for the final video stage.
// Even/odd byte palette RAMs feed a two-stage pixel pipeline gated by pxl_cen.
module jtbubl_colmix #(
  parameter SIMFILE_LO = "pal_lo.hex",
  parameter SIMFILE_HI = "pal_hi.hex"
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [7:0] col_addr,
  input  logic       video_en,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0] ram_lo [0:255];
  logic [7:0] ram_hi [0:255];

  logic       we;
  logic [7:0] cpu_lo;
  logic [7:0] cpu_hi;
  logic       cpu_sel;

  logic [7:0] pix_rg;
  logic [3:0] pix_b;
  logic       hb1;
  logic       vb1;
  logic       en1;
  logic       show1;

  assign we    = pal_cs & ~cpu_rnw;
  assign show1 = hb1 & vb1 & en1;

  // Storage is never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we & ~cpu_addr[0])
      ram_lo[cpu_addr[8:1]] <= cpu_dout;
    if (we & cpu_addr[0])
      ram_hi[cpu_addr[8:1]] <= cpu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_lo   <= 8'd0;
      cpu_hi   <= 8'd0;
      cpu_sel  <= 1'b0;
      pal_dout <= 8'd0;
    end else begin
      cpu_lo   <= ram_lo[cpu_addr[8:1]];
      cpu_hi   <= ram_hi[cpu_addr[8:1]];
      cpu_sel  <= cpu_addr[0];
      pal_dout <= cpu_sel ? cpu_hi : cpu_lo;
    end
  end

  // Stage 1: RAM read plus blanking/enable sample for the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_rg <= 8'd0;
      pix_b  <= 4'd0;
      hb1    <= 1'b0;
      vb1    <= 1'b0;
      en1    <= 1'b0;
    end else if (pxl_cen) begin
      pix_rg <= ram_lo[col_addr];
      pix_b  <= ram_hi[col_addr][7:4];
      hb1    <= LHBL;
      vb1    <= LVBL;
      en1    <= video_en;
    end
  end

  // Stage 2: blanked colour out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      red      <= show1 ? pix_rg[7:4] : 4'd0;
      green    <= show1 ? pix_rg[3:0] : 4'd0;
      blue     <= show1 ? pix_b       : 4'd0;
      LHBL_dly <= hb1;
      LVBL_dly <= vb1;
    end
  end

endmodule
